// File: rtl/branch_predictor_2bit_pkg.sv
// Shared types and constants for the 2-bit branch history table.
// The tag field is sized for the smallest legal table and zero-extended for larger ones.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Opcode prefix marking a control-transfer instruction in EX.
  localparam logic [2:0] OP_CTRL = 3'b110;

  // Widest tag needed: 30 - log2(2).
  localparam int TAG_MAX_W = 29;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } bht_entry_t;

endpackage

// File: rtl/branch_predictor_2bit_if.sv
// Fetch-lookup and EX-training signals between the pipeline and the predictor.
interface branch_predictor_2bit_if;

  logic [31:0] pc_IF;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        br_valid_EX;
  logic [31:0] pc_EX;
  logic        PCSel_EX;
  logic [31:0] alu;
  logic        pred_taken_EX;
  logic [31:0] pred_target_EX;
  logic        mispredict_o;
  logic [31:0] br_count_o;
  logic [31:0] miss_count_o;

  modport slave (
    input  pc_IF, br_valid_EX, pc_EX, PCSel_EX, alu, pred_taken_EX, pred_target_EX,
    output pred_taken_o, pred_target_o, mispredict_o, br_count_o, miss_count_o
  );

  modport master (
    output pc_IF, br_valid_EX, pc_EX, PCSel_EX, alu, pred_taken_EX, pred_target_EX,
    input  pred_taken_o, pred_target_o, mispredict_o, br_count_o, miss_count_o
  );

endinterface

// File: rtl/branch_predictor_2bit_sat_ctr2.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped BHT with 2-bit counters and stored targets: combinational
// next-PC lookup for fetch, training from resolved EX branches, miss statistics.
module branch_predictor_2bit
  import bp_pkg::*;
#(
  parameter int BHT_ENTRIES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  branch_predictor_2bit_if.slave  bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] pc);
    logic [TAG_W-1:0] t;
    t = pc[31:IDX_W+2];
    return TAG_MAX_W'(t);
  endfunction

  bht_entry_t table_q [BHT_ENTRIES];

  // Lookup side
  logic [IDX_W-1:0] rd_idx;
  bht_entry_t       rd_entry;
  logic             rd_hit;
  logic             pred_taken;
  logic [31:0]      pc_if_plus4;

  assign rd_idx      = bus.pc_IF[IDX_W+1:2];
  assign rd_entry    = table_q[rd_idx];
  assign rd_hit      = rd_entry.valid && (rd_entry.tag == tag_of(bus.pc_IF));
  assign pc_if_plus4 = bus.pc_IF + 32'd4;
  assign pred_taken  = rd_hit && rd_entry.ctr[1];

  assign bus.pred_taken_o  = pred_taken;
  assign bus.pred_target_o = pred_taken ? rd_entry.target : pc_if_plus4;

  // Update side
  logic [IDX_W-1:0]     wr_idx;
  logic [TAG_MAX_W-1:0] wr_tag;
  bht_entry_t           wr_entry;
  logic                 wr_hit;
  logic [1:0]           ctr_next;
  logic [31:0]          pc_ex_plus4;
  logic [31:0]          actual_next;
  logic [31:0]          predicted_next;
  logic                 mispredict;

  assign wr_idx   = bus.pc_EX[IDX_W+1:2];
  assign wr_tag   = tag_of(bus.pc_EX);
  assign wr_entry = table_q[wr_idx];
  assign wr_hit   = wr_entry.valid && (wr_entry.tag == wr_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr      (wr_entry.ctr),
    .taken    (bus.PCSel_EX),
    .ctr_next (ctr_next)
  );

  assign pc_ex_plus4    = bus.pc_EX + 32'd4;
  assign actual_next    = bus.PCSel_EX      ? bus.alu            : pc_ex_plus4;
  assign predicted_next = bus.pred_taken_EX ? bus.pred_target_EX : pc_ex_plus4;
  assign mispredict     = bus.br_valid_EX && (predicted_next != actual_next);
  assign bus.mispredict_o = mispredict;

  // Each entry is its own flop group so valid can be cleared asynchronously.
  for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_entry
    bht_entry_t entry_reg;
    logic       sel;

    assign sel = bus.br_valid_EX && (wr_idx == IDX_W'(gi));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_reg <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end else if (sel) begin
        if (wr_hit) begin
          entry_reg.ctr <= ctr_next;
          if (bus.PCSel_EX) entry_reg.target <= bus.alu;
        end else if (bus.PCSel_EX) begin
          entry_reg <= '{valid: 1'b1, tag: wr_tag, target: bus.alu, ctr: CTR_WT};
        end
      end
    end

    assign table_q[gi] = entry_reg;
  end

  // Statistics wrap modulo 2^32.
  logic [31:0] br_count_reg;
  logic [31:0] miss_count_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_count_reg   <= '0;
      miss_count_reg <= '0;
    end else begin
      if (bus.br_valid_EX) br_count_reg   <= br_count_reg + 32'd1;
      if (mispredict)      miss_count_reg <= miss_count_reg + 32'd1;
    end
  end

  assign bus.br_count_o   = br_count_reg;
  assign bus.miss_count_o = miss_count_reg;

endmodule
